lcd_nibble_ctrl: RTL

LCD_NIBBLE_CTRL -- requirements
Module: lcd_nibble_ctrl

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_delay_counter.sv | 36 +++
 rtl/lcd_nibble_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style 4-bit LCD write controller:
// FSM states, LCDCON bit map, slow opcodes and delay-counter sizing.
package lcd_pkg;

    localparam int CNT_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP_HI,
        ST_PULSE_HI,
        ST_HOLD_HI,
        ST_SETUP_LO,
        ST_PULSE_LO,
        ST_HOLD_LO,
        ST_EXEC
    } lcd_state_e;

    localparam int CON_BUSY  = 0;
    localparam int CON_RS    = 1;
    localparam int CON_OVF   = 2;
    localparam int CON_NIB   = 3;
    localparam int CON_LCDEN = 7;

    localparam logic [7:0] OP_CLEAR = 8'h01;
    localparam logic [7:0] OP_HOME  = 8'h02;

    // Value to load for a state lasting n clocks; a length of 0 behaves as 1.
    function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
        return (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Down-counter timing each controller phase; done_o is high while the
// count sits at zero, so a load of N-1 spans exactly N clocks.
module lcd_delay_counter
    import lcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_ctrl.sv
// Byte-to-LCD writer: LCDCON/LCDDAT registers and an FSM that sends a byte
// as two 4-bit nibbles with setup/EN-pulse/hold timing, then waits out execution.
module lcd_nibble_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned PULSE_CYC     = 25,
    parameter int unsigned HOLD_CYC      = 25,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 82000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] reg_data_in,
    input  logic       lcdcon_reg_wr_en,
    output logic [7:0] lcdcon_reg_out,
    input  logic       lcddat_reg_wr_en,
    output logic [7:0] lcddat_reg_out,
    output logic       lcdif_set_en,
    output logic [3:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam logic [CNT_W-1:0] SETUP_LD = cyc_load(SETUP_CYC);
    localparam logic [CNT_W-1:0] PULSE_LD = cyc_load(PULSE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = cyc_load(HOLD_CYC);
    localparam logic [CNT_W-1:0] EXEC_LD  = cyc_load(EXEC_CYC);
    localparam logic [CNT_W-1:0] LONG_LD  = cyc_load(LONG_EXEC_CYC);

    lcd_state_e       state_q, state_d;
    logic             rs_q, rs_d, nib_q, nib_d, ovf_q, ovf_d, lcden_q, lcden_d;
    logic [7:0]       dat_q, dat_d;
    logic             xrs_q, xrs_d, xnib_q, xnib_d;
    logic             cnt_load, cnt_done;
    logic [CNT_W-1:0] cnt_val, exec_ld;
    logic             busy, start, abort;

    assign busy    = (state_q != ST_IDLE);
    assign start   = lcddat_reg_wr_en && lcden_q && !busy;
    assign abort   = lcdcon_reg_wr_en && !reg_data_in[CON_LCDEN];
    assign exec_ld = (!xrs_q && (dat_q == OP_CLEAR || dat_q == OP_HOME)) ? LONG_LD : EXEC_LD;

    // The transfer uses its own RS/NIB copies so LCDCON can be rewritten mid-transfer.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        rs_d    = rs_q;
        nib_d   = nib_q;
        ovf_d   = ovf_q;
        lcden_d = lcden_q;
        dat_d   = dat_q;
        xrs_d   = xrs_q;
        xnib_d  = xnib_q;
        if (lcdcon_reg_wr_en) begin
            rs_d    = reg_data_in[CON_RS];
            nib_d   = reg_data_in[CON_NIB];
            lcden_d = reg_data_in[CON_LCDEN];
            if (!reg_data_in[CON_OVF]) begin
                ovf_d = 1'b0;
            end
        end
        if (lcddat_reg_wr_en) begin
            if (busy) begin
                ovf_d = 1'b1;
            end else begin
                dat_d = reg_data_in;
                if (lcden_q) begin
                    xrs_d  = rs_q;
                    xnib_d = nib_q;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            ST_IDLE:     if (start)    begin state_d = ST_SETUP_HI; cnt_load = 1'b1; cnt_val = SETUP_LD; end
            ST_SETUP_HI: if (cnt_done) begin state_d = ST_PULSE_HI; cnt_load = 1'b1; cnt_val = PULSE_LD; end
            ST_PULSE_HI: if (cnt_done) begin state_d = ST_HOLD_HI;  cnt_load = 1'b1; cnt_val = HOLD_LD;  end
            ST_HOLD_HI: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    if (xnib_q) begin
                        state_d = ST_EXEC;
                        cnt_val = exec_ld;
                    end else begin
                        state_d = ST_SETUP_LO;
                        cnt_val = SETUP_LD;
                    end
                end
            end
            ST_SETUP_LO: if (cnt_done) begin state_d = ST_PULSE_LO; cnt_load = 1'b1; cnt_val = PULSE_LD; end
            ST_PULSE_LO: if (cnt_done) begin state_d = ST_HOLD_LO;  cnt_load = 1'b1; cnt_val = HOLD_LD;  end
            ST_HOLD_LO:  if (cnt_done) begin state_d = ST_EXEC;     cnt_load = 1'b1; cnt_val = exec_ld;  end
            ST_EXEC:     if (cnt_done) begin state_d = ST_IDLE; end
            default:     state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            cnt_load = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rs_q    <= 1'b0;
            nib_q   <= 1'b0;
            ovf_q   <= 1'b0;
            lcden_q <= 1'b0;
            dat_q   <= '0;
            xrs_q   <= 1'b0;
            xnib_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rs_q    <= rs_d;
            nib_q   <= nib_d;
            ovf_q   <= ovf_d;
            lcden_q <= lcden_d;
            dat_q   <= dat_d;
            xrs_q   <= xrs_d;
            xnib_q  <= xnib_d;
        end
    end

    lcd_delay_counter u_delay (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_val),
        .done_o    (cnt_done)
    );

    // Pins decode from registered state only; EXEC keeps the last nibble sent.
    always_comb begin
        lcd_data = 4'h0;
        lcd_rs   = 1'b0;
        unique case (state_q)
            ST_IDLE:                              lcd_data = 4'h0;
            ST_SETUP_HI, ST_PULSE_HI, ST_HOLD_HI: lcd_data = dat_q[7:4];
            ST_SETUP_LO, ST_PULSE_LO, ST_HOLD_LO: lcd_data = dat_q[3:0];
            ST_EXEC:                              lcd_data = xnib_q ? dat_q[7:4] : dat_q[3:0];
            default:                              lcd_data = 4'h0;
        endcase
        if (busy) begin
            lcd_rs = xrs_q;
        end
    end

    assign lcd_en         = (state_q == ST_PULSE_HI) || (state_q == ST_PULSE_LO);
    assign lcd_rw         = 1'b0;
    assign lcdif_set_en   = (state_q == ST_EXEC) && cnt_done;
    assign lcdcon_reg_out = {lcden_q, 3'b000, nib_q, ovf_q, rs_q, busy};
    assign lcddat_reg_out = dat_q;

endmodule
